tl_cntr_param: RTL and testbench

//  Parametrised two-road traffic light controller with protected left-turn phases.

---
 rtl/tl_cntr_param.sv | 190 +++++++++++++++++++
 tb/tb_tl_cntr_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tl_cntr_param.sv
// ---------------------------------------------------------------------------
// tl_cntr_param
//   Two-road traffic light controller with protected left-turn phases and
//   parameterised phase timing. A straight green phase is extended by its
//   road sensor. It lasts at least MIN_GRN cycles and at most MAX_GRN cycles.
//   A left-turn phase runs only when that road has a latched left-turn
//   request at the end of its yellow phase.
//
// Parameters
//   CNT_W    phase timer width; must be able to hold MAX_GRN-1
//   MIN_GRN  minimum green cycles per straight phase (>=1)
//   MAX_GRN  maximum green cycles per straight phase (>=MIN_GRN)
//   YEL      cycles in every yellow phase (>=1)
//   LFT      cycles in every left-turn phase (>=1)
//
// Ports
//   clk         in   rising-edge system clock
//   reset       in   asynchronous active-high reset. Release must be
//                    synchronous to clk.
//   Ta, Tb      in   traffic present on road A / road B
//   left_req_a  in   left-turn request (pulse or level), road A
//   left_req_b  in   left-turn request (pulse or level), road B
//   La, Lb      out  lamp codes: 00 GREEN, 01 YELLOW, 10 RED, 11 LEFT
//   state       out  current state register (S0..S7)
//
// Phase order
//   S0 A_GRN -> S1 A_YEL -> [S2 A_LFT -> S3 A_LYEL] ->
//   S4 B_GRN -> S5 B_YEL -> [S6 B_LFT -> S7 B_LYEL] -> S0
//
// The lamps are Moore outputs decoded only from the state register.
// ---------------------------------------------------------------------------
module tl_cntr_param #(
    parameter int CNT_W   = 5,
    parameter int MIN_GRN = 4,
    parameter int MAX_GRN = 16,
    parameter int YEL     = 2,
    parameter int LFT     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       left_req_a,
    input  logic       left_req_b,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_A_GRN  = 3'd0,
        S_A_YEL  = 3'd1,
        S_A_LFT  = 3'd2,
        S_A_LYEL = 3'd3,
        S_B_GRN  = 3'd4,
        S_B_YEL  = 3'd5,
        S_B_LFT  = 3'd6,
        S_B_LYEL = 3'd7
    } state_e;

    localparam logic [1:0] LAMP_GREEN  = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_RED    = 2'b10;
    localparam logic [1:0] LAMP_LEFT   = 2'b11;

    // The timer value on the last cycle of each phase. Computing these once
    // keeps the comparisons at timer width.
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GRN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GRN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YEL - 1);
    localparam logic [CNT_W-1:0] LFT_LAST = CNT_W'(LFT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic              req_a_q, req_a_d;
    logic              req_b_q, req_b_d;

    // -----------------------------------------------------------------------
    // State, timer and request registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_A_GRN;
            timer_q <= '0;
            req_a_q <= 1'b0;
            req_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            req_a_q <= req_a_d;
            req_b_q <= req_b_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // A green phase ends once the minimum time has elapsed and either the
    // road is empty or the maximum time has been reached. Ta and Tb are
    // looked at only in their own green state.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_A_GRN: begin
                if (timer_q >= MIN_LAST && (!Ta || timer_q == MAX_LAST))
                    state_d = S_A_YEL;
            end
            S_A_YEL: begin
                if (timer_q == YEL_LAST)
                    state_d = req_a_q ? S_A_LFT : S_B_GRN;
            end
            S_A_LFT: begin
                if (timer_q == LFT_LAST)
                    state_d = S_A_LYEL;
            end
            S_A_LYEL: begin
                if (timer_q == YEL_LAST)
                    state_d = S_B_GRN;
            end
            S_B_GRN: begin
                if (timer_q >= MIN_LAST && (!Tb || timer_q == MAX_LAST))
                    state_d = S_B_YEL;
            end
            S_B_YEL: begin
                if (timer_q == YEL_LAST)
                    state_d = req_b_q ? S_B_LFT : S_A_GRN;
            end
            S_B_LFT: begin
                if (timer_q == LFT_LAST)
                    state_d = S_B_LYEL;
            end
            S_B_LYEL: begin
                if (timer_q == YEL_LAST)
                    state_d = S_A_GRN;
            end
            default: state_d = S_A_GRN;
        endcase
    end

    // -----------------------------------------------------------------------
    // Phase timer: counts the cycles spent in the current state. It restarts
    // at 0 on every state change and saturates rather than wrapping.
    // -----------------------------------------------------------------------
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q)
            timer_d = '0;
        else if (timer_q != CNT_SAT)
            timer_d = timer_q + 1'b1;
    end

    // -----------------------------------------------------------------------
    // Left-turn request latches
    // A request is consumed on the edge that enters the road's left phase.
    // A request that arrives on that same edge is dropped. The clear has
    // priority because the request is being served in that phase.
    // -----------------------------------------------------------------------
    always_comb begin
        req_a_d = req_a_q | left_req_a;
        req_b_d = req_b_q | left_req_b;
        if (state_d == S_A_LFT && state_q != S_A_LFT)
            req_a_d = 1'b0;
        if (state_d == S_B_LFT && state_q != S_B_LFT)
            req_b_d = 1'b0;
    end

    // -----------------------------------------------------------------------
    // Output decode (Moore). In every state at least one road is RED.
    // -----------------------------------------------------------------------
    always_comb begin
        La = LAMP_RED;
        Lb = LAMP_RED;
        unique case (state_q)
            S_A_GRN:            La = LAMP_GREEN;
            S_A_YEL, S_A_LYEL:  La = LAMP_YELLOW;
            S_A_LFT:            La = LAMP_LEFT;
            S_B_GRN:            Lb = LAMP_GREEN;
            S_B_YEL, S_B_LYEL:  Lb = LAMP_YELLOW;
            S_B_LFT:            Lb = LAMP_LEFT;
            default: begin
                La = LAMP_RED;
                Lb = LAMP_RED;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_tl_cntr_param.sv
// ---------------------------------------------------------------------------
// tb_tl_cntr_param
//   Directed testbench for tl_cntr_param with the default parameters
//   (MIN_GRN=4, MAX_GRN=16, YEL=2, LFT=3). The expected state sequences and
//   lamp codes are worked out by hand from the phase timing.
// ---------------------------------------------------------------------------
module tb_tl_cntr_param;

  logic       clk;
  logic       reset;
  logic       Ta;
  logic       Tb;
  logic       left_req_a;
  logic       left_req_b;
  logic [1:0] La;
  logic [1:0] Lb;
  logic [2:0] state;

  int n_vec;
  int n_err;

  tl_cntr_param dut (
    .clk        (clk),
    .reset      (reset),
    .Ta         (Ta),
    .Tb         (Tb),
    .left_req_a (left_req_a),
    .left_req_b (left_req_b),
    .La         (La),
    .Lb         (Lb),
    .state      (state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Lamp codes expected in each state: 0 GREEN, 1 YELLOW, 2 RED, 3 LEFT.
  function automatic int exp_la(input int s);
    case (s)
      0:       return 0;
      1, 3:    return 1;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int exp_lb(input int s);
    case (s)
      4:       return 0;
      5, 7:    return 1;
      6:       return 3;
      default: return 2;
    endcase
  endfunction

  // Neither road may ever show a non-RED lamp while the other does.
  always @(negedge clk) begin
    check("exclusive", int'(La != 2'b10 && Lb != 2'b10), 0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect state s to be held for exactly n cycles from now.
  task automatic hold(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("state_in_%0d", s), int'(state), s);
      check($sformatf("la_in_%0d", s), int'(La), exp_la(s));
      check($sformatf("lb_in_%0d", s), int'(Lb), exp_lb(s));
      tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    check("reset_state", int'(state), 0);
    check("reset_la", int'(La), 0);
    check("reset_lb", int'(Lb), 2);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b1;
    Ta         = 1'b1;
    Tb         = 1'b0;
    left_req_a = 1'b0;
    left_req_b = 1'b0;

    // 1. Ta=1: green held to MAX_GRN (16 cycles), then yellow.
    do_reset();
    hold(0, 16);
    check("t1_yel_state", int'(state), 1);
    check("t1_yel_la", int'(La), 1);
    hold(1, 2);
    hold(4, 4);
    hold(5, 2);
    check("t1_back_s0", int'(state), 0);

    // 2. Ta=0: green lasts MIN_GRN, yellow 2 cycles, then road B.
    Ta = 1'b0;
    do_reset();
    hold(0, 4);
    hold(1, 2);
    check("t2_s4_state", int'(state), 4);
    check("t2_s4_la", int'(La), 2);
    check("t2_s4_lb", int'(Lb), 0);
    hold(4, 4);
    hold(5, 2);

    // 3. A one-cycle left request on road A gives one left phase.
    check("t3_start", int'(state), 0);
    left_req_a = 1'b1;
    tick();
    left_req_a = 1'b0;
    hold(0, 3);
    hold(1, 2);
    hold(2, 3);
    hold(3, 2);
    check("t3_s4", int'(state), 4);
    check("t3_req_a_clr", int'(dut.req_a_q), 0);
    hold(4, 4);
    hold(5, 2);
    hold(0, 4);
    hold(1, 2);
    check("t3_no_reserve", int'(state), 4);

    // 4. left_req_b held high: every B cycle includes S6.
    left_req_b = 1'b1;
    hold(4, 4);
    hold(5, 2);
    check("t4_s6_a", int'(state), 6);
    check("t4_req_b_clr_a", int'(dut.req_b_q), 0);
    hold(6, 3);
    hold(7, 2);
    hold(0, 4);
    hold(1, 2);
    hold(4, 4);
    // Release the level. The request stays latched. A pulse on the edge
    // that enters S6 must be absorbed by that service.
    left_req_b = 1'b0;
    check("t4_s5_t0", int'(state), 5);
    tick();
    check("t4_s5_t1", int'(state), 5);
    left_req_b = 1'b1;
    tick();
    left_req_b = 1'b0;
    check("t4_s6_b", int'(state), 6);
    check("t4_req_b_clr_b", int'(dut.req_b_q), 0);
    hold(6, 3);
    hold(7, 2);
    hold(0, 4);
    hold(1, 2);
    hold(4, 4);
    hold(5, 2);
    check("t4_no_reserve", int'(state), 0);

    // 5. Asynchronous reset while in S6 at timer=1 discards pending requests.
    left_req_b = 1'b1;
    tick();
    left_req_b = 1'b0;
    hold(0, 3);
    hold(1, 2);
    hold(4, 4);
    hold(5, 2);
    check("t5_s6", int'(state), 6);
    left_req_a = 1'b1;
    tick();
    left_req_a = 1'b0;
    check("t5_s6_t1", int'(state), 6);
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_state", int'(state), 0);
    check("t5_async_la", int'(La), 0);
    check("t5_async_lb", int'(Lb), 2);
    tick();
    reset = 1'b0;
    check("t5_req_a_gone", int'(dut.req_a_q), 0);
    hold(0, 4);
    hold(1, 2);
    check("t5_no_left", int'(state), 4);

    // 6. Both requests pending, Ta=Tb=0: full order 0..7 then 0.
    hold(4, 4);
    hold(5, 2);
    check("t6_start", int'(state), 0);
    left_req_a = 1'b1;
    left_req_b = 1'b1;
    tick();
    left_req_a = 1'b0;
    left_req_b = 1'b0;
    hold(0, 3);
    hold(1, 2);
    hold(2, 3);
    hold(3, 2);
    hold(4, 4);
    hold(5, 2);
    hold(6, 3);
    hold(7, 2);
    check("t6_end", int'(state), 0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
